log_window_scheduler: RTL

- Sequences the 5x5 Laplacian-of-Gaussian edge kernel over a raster-scan 8-bit grayscale image.
- Buffers four previous image lines and assembles a 5x5 window each time a pixel is accepted. The window is presented to the combinational edge kernel and the kernel result is registered to a valid/ready output stream.
- Sits between the decoded-pixel stream (upstream) and the edge-image consumer (downstream). Emits only interior pixels: (IMG_WIDTH-4) x (IMG_HEIGHT-4) outputs per frame.

---
 rtl/log_window_scheduler.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/log_window_scheduler.sv
// Raster-scan 5x5 window sequencer for an external Laplacian-of-Gaussian kernel.
// Four line buffers feed a 5x5 shift window; interior results go out on a valid/ready stream.
module log_window_scheduler #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_pixel,
  output logic [199:0] win_out,
  input  logic [7:0]   kernel_pixel,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_pixel,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never waits on ready, and a held valid keeps its data stable.
  state_t          state_q, state_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   col_q, col_d;
  logic [199:0]    win_q, win_d;
  logic            pend_q, pend_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      out_pixel_q, out_pixel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // One word per column: byte3 is the line four rows up, byte0 the line just above.
  logic [31:0]     lb_q [IMG_WIDTH];
  logic [31:0]     lb_rd;
  logic            in_ready_w, accept, load, last_px, emit;

  always_comb begin
    lb_rd       = lb_q[col_q];
    in_ready_w  = (state_q == ACTIVE) && (!out_valid_q || out_ready);
    accept      = in_ready_w && in_valid;
    load        = pend_q && (!out_valid_q || out_ready);
    last_px     = (row_q == RW'(IMG_HEIGHT - 1)) && (col_q == CW'(IMG_WIDTH - 1));
    emit        = (row_q >= RW'(4)) && (col_q >= CW'(4));

    state_d     = state_q;
    row_d       = row_q;
    col_d       = col_q;
    win_d       = win_q;
    pend_d      = pend_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    if (accept) begin
      for (int r = 0; r < 5; r++) begin
        for (int c = 0; c < 4; c++) begin
          win_d[8*(5*r+c) +: 8] = win_q[8*(5*r+c+1) +: 8];
        end
      end
      win_d[8*4  +: 8] = lb_rd[31:24];
      win_d[8*9  +: 8] = lb_rd[23:16];
      win_d[8*14 +: 8] = lb_rd[15:8];
      win_d[8*19 +: 8] = lb_rd[7:0];
      win_d[8*24 +: 8] = in_pixel;
      pend_d = emit;
      if (col_q == CW'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (load) begin
      pend_d = 1'b0;
    end

    // The pending window is only ever loaded when the output slot is free or
    // draining this cycle, which is exactly when in_ready can be high.
    if (load) begin
      out_valid_d = 1'b1;
      out_pixel_d = kernel_pixel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACTIVE;
          busy_d  = 1'b1;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ACTIVE: begin
        if (accept && last_px) state_d = DRAIN;
      end
      DRAIN: begin
        if (!pend_q && out_valid_q && out_ready) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      pend_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      pend_q      <= pend_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) lb_q[col_q] <= {lb_rd[23:0], in_pixel};
  end

  assign in_ready  = in_ready_w;
  assign win_out   = win_q;
  assign out_valid = out_valid_q;
  assign out_pixel = out_pixel_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
